// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the clk_divider block.
//   state_t      : divider FSM states (IDLE, RUN, STOP)
//   MIN_RATIO    : smallest legal division ratio
//   clamp_ratio  : lifts ratio requests below MIN_RATIO up to MIN_RATIO
// No ports (package).
// -----------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int unsigned MIN_RATIO = 2;

    // Ratios 0 and 1 cannot form a 50% clock with a high and a low phase,
    // so they are treated as the smallest legal ratio. Works on a 32-bit
    // container so any ratio field up to 32 bits can use it.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        logic [31:0] result;
        if (ratio < 32'(MIN_RATIO)) begin
            result = 32'(MIN_RATIO);
        end else begin
            result = ratio;
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_div_ratio_reg.sv
// -----------------------------------------------------------------------------
// clk_div_ratio_reg
// Holds the pending and active division ratios. A load captures a clamped
// request as pending; the FSM's apply strobe (period boundary or IDLE) moves
// a valid pending ratio into the active register and pulses upd_ack.
// Ports:
//   bclk       in   clock
//   rst        in   synchronous active-high reset
//   load       in   capture div_ratio as pending
//   div_ratio  in   requested ratio (WIDTH)
//   apply      in   boundary/apply strobe from the FSM
//   ratio      out  active ratio (WIDTH), registered
//   upd_ack    out  one-cycle pulse when pending becomes active, registered
// -----------------------------------------------------------------------------
module clk_div_ratio_reg
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEF_RATIO = 2
) (
    input  logic             bclk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             apply,
    output logic [WIDTH-1:0] ratio,
    output logic             upd_ack
);

    localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(clamp_ratio(32'(DEF_RATIO)));

    logic [WIDTH-1:0] clamped_s;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] act_r;
    logic             pend_valid_r;
    logic             ack_r;

    // Clamp the incoming request before it is stored.
    always_comb begin
        clamped_s = WIDTH'(clamp_ratio(32'(div_ratio)));
    end

    // Pending/active ratio registers. The apply check reads the pending state
    // as it was before this edge, so a load landing on a boundary waits for
    // the following boundary.
    always_ff @(posedge bclk) begin
        if (rst) begin
            pend_r       <= RESET_RATIO;
            act_r        <= RESET_RATIO;
            pend_valid_r <= 1'b0;
            ack_r        <= 1'b0;
        end else begin
            if (apply && pend_valid_r) begin
                act_r        <= pend_r;
                ack_r        <= 1'b1;
                pend_valid_r <= 1'b0;
            end else begin
                ack_r        <= 1'b0;
            end
            if (load) begin
                pend_r       <= clamped_s;
                pend_valid_r <= 1'b1;
            end
        end
    end

    assign ratio   = act_r;
    assign upd_ack = ack_r;

endmodule

// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
// Programmable integer divider on the buffered clock. Produces a registered
// ~50% divided clock whose ratio changes and start/stop only take effect on
// period boundaries, so no runt pulses are generated.
// Ports:
//   bclk       in   buffered clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   run request (level)
//   load       in   one-cycle strobe: capture div_ratio as pending ratio
//   div_ratio  in   requested ratio N (WIDTH), 0/1 clamped to 2
//   dclk       out  divided clock, registered
//   dclk_rise  out  high in the first high bclk cycle of each dclk period
//   run        out  high while in RUN or STOP
//   ratio_o    out  active ratio (WIDTH)
//   upd_ack    out  pulse when the pending ratio becomes active
// -----------------------------------------------------------------------------
module clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEF_RATIO = 2
) (
    input  logic             bclk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_ratio,
    output logic             dclk,
    output logic             dclk_rise,
    output logic             run,
    output logic [WIDTH-1:0] ratio_o,
    output logic             upd_ack
);

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic             dclk_r;
    logic             rise_r;
    logic             run_r;

    logic [WIDTH-1:0] ratio_s;
    logic             ack_s;
    logic [WIDTH-1:0] last_s;
    logic [WIDTH:0]   high_cnt_s;
    logic [WIDTH:0]   cnt_inc_s;
    logic             wrap_s;
    logic             apply_s;
    logic [WIDTH-1:0] cnt_adv_s;
    logic             dclk_adv_s;

    clk_div_ratio_reg #(
        .WIDTH     (WIDTH),
        .DEF_RATIO (DEF_RATIO)
    ) u_ratio_reg (
        .bclk      (bclk),
        .rst       (rst),
        .load      (load),
        .div_ratio (div_ratio),
        .apply     (apply_s),
        .ratio     (ratio_s),
        .upd_ack   (ack_s)
    );

    // Period arithmetic. Sums are one bit wider so N = 2^WIDTH-1 does not
    // overflow when computing the high count or the incremented counter.
    always_comb begin
        last_s     = ratio_s - {{(WIDTH-1){1'b0}}, 1'b1};
        high_cnt_s = ({1'b0, ratio_s} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        cnt_inc_s  = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
        wrap_s     = (cnt_r == last_s);
    end

    // Next counter/dclk value for a counting state (RUN or STOP that resumes).
    // dclk is high while the counter is below the high count, so odd ratios
    // spend the extra cycle high.
    always_comb begin
        cnt_adv_s  = {WIDTH{1'b0}};
        dclk_adv_s = 1'b0;
        if (wrap_s) begin
            cnt_adv_s  = {WIDTH{1'b0}};
            dclk_adv_s = 1'b1;
        end else begin
            cnt_adv_s  = cnt_inc_s[WIDTH-1:0];
            dclk_adv_s = (cnt_inc_s < high_cnt_s);
        end
    end

    // Pending ratios are applied at any IDLE edge or at a period boundary.
    always_comb begin
        apply_s = 1'b0;
        case (state_r)
            IDLE:    apply_s = 1'b1;
            RUN:     apply_s = wrap_s;
            STOP:    apply_s = wrap_s;
            default: apply_s = 1'b0;
        endcase
    end

    // Divider FSM with counter and registered dclk/dclk_rise/run.
    always_ff @(posedge bclk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {WIDTH{1'b0}};
            dclk_r  <= 1'b0;
            rise_r  <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= {WIDTH{1'b0}};
                    if (en) begin
                        state_r <= RUN;
                        dclk_r  <= 1'b1;
                        rise_r  <= 1'b1;
                        run_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        dclk_r  <= 1'b0;
                        rise_r  <= 1'b0;
                        run_r   <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_r   <= cnt_adv_s;
                    dclk_r  <= dclk_adv_s;
                    rise_r  <= wrap_s;
                    run_r   <= 1'b1;
                    state_r <= en ? RUN : STOP;
                end
                STOP: begin
                    if (en) begin
                        // Resumed before the boundary: the period continues unbroken.
                        state_r <= RUN;
                        cnt_r   <= cnt_adv_s;
                        dclk_r  <= dclk_adv_s;
                        rise_r  <= wrap_s;
                        run_r   <= 1'b1;
                    end else if (wrap_s) begin
                        // Last period done: park low without starting a new one.
                        state_r <= IDLE;
                        cnt_r   <= {WIDTH{1'b0}};
                        dclk_r  <= 1'b0;
                        rise_r  <= 1'b0;
                        run_r   <= 1'b0;
                    end else begin
                        state_r <= STOP;
                        cnt_r   <= cnt_adv_s;
                        dclk_r  <= dclk_adv_s;
                        rise_r  <= 1'b0;
                        run_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {WIDTH{1'b0}};
                    dclk_r  <= 1'b0;
                    rise_r  <= 1'b0;
                    run_r   <= 1'b0;
                end
            endcase
        end
    end

    assign dclk      = dclk_r;
    assign dclk_rise = rise_r;
    assign run       = run_r;
    assign ratio_o   = ratio_s;
    assign upd_ack   = ack_s;

endmodule

// File: tb/tb_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_divider
// Cycle vector table for clk_divider (WIDTH=8, DEF_RATIO=2). Each record holds
// the inputs for one bclk edge and the outputs expected right after it.
// -----------------------------------------------------------------------------
module tb_clk_divider;

    logic       bclk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] div_ratio;
    logic       dclk;
    logic       dclk_rise;
    logic       run;
    logic [7:0] ratio_o;
    logic       upd_ack;

    typedef struct packed {
        logic       dclk;
        logic       rise;
        logic       run;
        logic [7:0] ratio;
        logic       ack;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       load;
        logic [7:0] div;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks;
    int   fails;

    clk_divider #(
        .WIDTH     (8),
        .DEF_RATIO (2)
    ) dut (
        .bclk      (bclk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .div_ratio (div_ratio),
        .dclk      (dclk),
        .dclk_rise (dclk_rise),
        .run       (run),
        .ratio_o   (ratio_o),
        .upd_ack   (upd_ack)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic add(input logic r, input logic e, input logic l, input int d,
                       input logic xd, input logic xr, input logic xn,
                       input int xratio, input logic xa);
        vec_t v;
        v.rst       = r;
        v.en        = e;
        v.load      = l;
        v.div       = 8'(d);
        v.exp.dclk  = xd;
        v.exp.rise  = xr;
        v.exp.run   = xn;
        v.exp.ratio = 8'(xratio);
        v.exp.ack   = xa;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t got;
        exp_t want;
        int   cyc;
        int   highs;

        checks    = 0;
        fails     = 0;
        rst       = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        div_ratio = 8'd0;

        //   rst en ld div | dclk rise run ratio ack
        // reset
        add(1, 0, 0, 0,   0, 0, 0, 2, 0);
        add(1, 0, 0, 0,   0, 0, 0, 2, 0);
        // en at DEF_RATIO=2: toggles every cycle
        add(0, 1, 0, 0,   1, 1, 1, 2, 0);
        add(0, 1, 0, 0,   0, 0, 1, 2, 0);
        add(0, 1, 0, 0,   1, 1, 1, 2, 0);
        add(0, 1, 0, 0,   0, 0, 1, 2, 0);
        add(0, 1, 0, 0,   1, 1, 1, 2, 0);
        // load 5 mid-period; applied at next wrap with upd_ack
        add(0, 1, 1, 5,   0, 0, 1, 2, 0);
        add(0, 1, 0, 0,   1, 1, 1, 5, 1);
        add(0, 1, 0, 0,   1, 0, 1, 5, 0);
        add(0, 1, 0, 0,   1, 0, 1, 5, 0);
        add(0, 1, 0, 0,   0, 0, 1, 5, 0);
        add(0, 1, 0, 0,   0, 0, 1, 5, 0);
        add(0, 1, 0, 0,   1, 1, 1, 5, 0);
        // load 0 then 1: clamped to 2, single ack
        add(0, 1, 1, 0,   1, 0, 1, 5, 0);
        add(0, 1, 1, 1,   1, 0, 1, 5, 0);
        add(0, 1, 0, 0,   0, 0, 1, 5, 0);
        add(0, 1, 0, 0,   0, 0, 1, 5, 0);
        add(0, 1, 0, 0,   1, 1, 1, 2, 1);
        add(0, 1, 0, 0,   0, 0, 1, 2, 0);
        add(0, 1, 0, 0,   1, 1, 1, 2, 0);
        // N=4, en dropped at cnt=1, then restart
        add(0, 1, 1, 4,   0, 0, 1, 2, 0);
        add(0, 1, 0, 0,   1, 1, 1, 4, 1);
        add(0, 1, 0, 0,   1, 0, 1, 4, 0);
        add(0, 0, 0, 0,   0, 0, 1, 4, 0);
        add(0, 0, 0, 0,   0, 0, 1, 4, 0);
        add(0, 0, 0, 0,   0, 0, 0, 4, 0);
        add(0, 0, 0, 0,   0, 0, 0, 4, 0);
        add(0, 0, 0, 0,   0, 0, 0, 4, 0);
        add(0, 1, 0, 0,   1, 1, 1, 4, 0);
        add(0, 1, 0, 0,   1, 0, 1, 4, 0);
        add(0, 1, 0, 0,   0, 0, 1, 4, 0);
        add(0, 1, 0, 0,   0, 0, 1, 4, 0);
        add(0, 1, 0, 0,   1, 1, 1, 4, 0);
        // go to N=3, then load 6 on the wrap edge: applies one period later
        add(0, 1, 1, 3,   1, 0, 1, 4, 0);
        add(0, 1, 0, 0,   0, 0, 1, 4, 0);
        add(0, 1, 0, 0,   0, 0, 1, 4, 0);
        add(0, 1, 0, 0,   1, 1, 1, 3, 1);
        add(0, 1, 0, 0,   1, 0, 1, 3, 0);
        add(0, 1, 0, 0,   0, 0, 1, 3, 0);
        add(0, 1, 1, 6,   1, 1, 1, 3, 0);
        add(0, 1, 0, 0,   1, 0, 1, 3, 0);
        add(0, 1, 0, 0,   0, 0, 1, 3, 0);
        add(0, 1, 0, 0,   1, 1, 1, 6, 1);
        // N=6, rst at cnt=2 with en held, restart after rst drops
        add(0, 1, 0, 0,   1, 0, 1, 6, 0);
        add(0, 1, 0, 0,   1, 0, 1, 6, 0);
        add(1, 1, 0, 0,   0, 0, 0, 2, 0);
        add(0, 1, 0, 0,   1, 1, 1, 2, 0);
        add(0, 1, 0, 0,   0, 0, 1, 2, 0);
        add(0, 1, 0, 0,   1, 1, 1, 2, 0);
        // stop, then load in IDLE: applied on the next IDLE edge
        add(0, 0, 0, 0,   0, 0, 1, 2, 0);
        add(0, 0, 0, 0,   0, 0, 0, 2, 0);
        add(0, 0, 1, 7,   0, 0, 0, 2, 0);
        add(0, 0, 0, 0,   0, 0, 0, 7, 1);
        add(0, 1, 0, 0,   1, 1, 1, 7, 0);
        // en dips for one cycle inside a period: period unbroken
        add(0, 0, 0, 0,   1, 0, 1, 7, 0);
        add(0, 1, 0, 0,   1, 0, 1, 7, 0);
        add(0, 1, 0, 0,   1, 0, 1, 7, 0);
        add(0, 1, 0, 0,   0, 0, 1, 7, 0);
        add(0, 1, 0, 0,   0, 0, 1, 7, 0);
        add(0, 1, 0, 0,   0, 0, 1, 7, 0);
        add(0, 1, 0, 0,   1, 1, 1, 7, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge bclk);
            rst       = vecs[i].rst;
            en        = vecs[i].en;
            load      = vecs[i].load;
            div_ratio = vecs[i].div;
            sb.push_back(vecs[i].exp);
            @(posedge bclk);
            #1;
            got.dclk  = dclk;
            got.rise  = dclk_rise;
            got.run   = run;
            got.ratio = ratio_o;
            got.ack   = upd_ack;
            want      = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL vec%0d: got dclk=%b rise=%b run=%b ratio=%0d ack=%b, expected dclk=%b rise=%b run=%b ratio=%0d ack=%b",
                         i, got.dclk, got.rise, got.run, got.ratio, got.ack,
                         want.dclk, want.rise, want.run, want.ratio, want.ack);
            end
        end

        // Free-running N=7 period: 7 cycles to the next rise, 4 of them high.
        @(negedge bclk);
        en    = 1'b1;
        load  = 1'b0;
        rst   = 1'b0;
        cyc   = 0;
        highs = 0;
        while (cyc < 50) begin
            @(posedge bclk);
            #1;
            cyc++;
            if (dclk === 1'b1) highs++;
            if (dclk_rise === 1'b1) break;
        end
        checks++;
        if (cyc != 7) begin
            fails++;
            $display("FAIL period_len: got %0d cycles, expected 7", cyc);
        end
        checks++;
        if (highs != 4) begin
            fails++;
            $display("FAIL high_len: got %0d high cycles, expected 4", highs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
